// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared constants, state encoding, conjugate twiddles and the
// bit-reversal helper for the streaming 8-point inverse FFT.
package ifft8_pkg;

    // Sample component width and Q16.16 fraction bits
    localparam int DW   = 32;
    localparam int FRAC = 16;
    // Transform length (fixed)
    localparam int N    = 8;
    // log2(N): arithmetic shift applied by the optional 1/N normalisation
    localparam int SCALE_SHIFT = 3;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        SCALE   = 2'd2,
        UNLOAD  = 2'd3
    } state_t;

    // Conjugate twiddles W^t = e^{+j*2*pi*t/8}, t = 0..3, in Q16.16
    localparam logic [DW-1:0] TW_RE [4] = '{
        32'h0001_0000, 32'h0000_B505, 32'h0000_0000, 32'hFFFF_4AFB
    };
    localparam logic [DW-1:0] TW_IM [4] = '{
        32'h0000_0000, 32'h0000_B505, 32'h0001_0000, 32'h0000_B505
    };

    // Reverse the three index bits (load-side address permutation)
    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/ifft8_butterfly.sv
// ifft8_butterfly: combinational radix-2 DIT butterfly, x = a + W*b and
// y = a - W*b. Each Q16.16 product is formed at full 64-bit precision and
// truncated toward -inf before the partial products are combined; all sums
// wrap modulo 2^DW.
module ifft8_butterfly
    import ifft8_pkg::*;
(
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [DW-1:0] w_re,
    input  logic [DW-1:0] w_im,
    output logic [DW-1:0] x_re,
    output logic [DW-1:0] x_im,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im
);

    // Signed Q16.16 multiply: keep product bits [DW+FRAC-1:FRAC]
    function automatic logic [DW-1:0] qmul(input logic signed [DW-1:0] x,
                                           input logic signed [DW-1:0] y);
        logic signed [2*DW-1:0] prod;
        prod = (2*DW)'(x) * (2*DW)'(y);
        return DW'(prod >>> FRAC);
    endfunction

    logic [DW-1:0] wb_re;
    logic [DW-1:0] wb_im;

    // Complex twiddle product, then the sum/difference pair
    always_comb begin
        wb_re = qmul(w_re, b_re) - qmul(w_im, b_im);
        wb_im = qmul(w_re, b_im) + qmul(w_im, b_re);
        x_re  = a_re + wb_re;
        x_im  = a_im + wb_im;
        y_re  = a_re - wb_re;
        y_im  = a_im - wb_im;
    end

endmodule

// File: rtl/ifft8_stream.sv
// ifft8_stream: sequential 8-point inverse FFT. Bins arrive serially and are
// stored bit-reversed, three in-place DIT stages run at one butterfly per
// clock, then time samples stream out in natural order.
// Optional macro IFFT_SCALE_EN: adds a one-cycle SCALE state applying >>>3
// to every buffer entry (1/N normalisation).
module ifft8_stream
    import ifft8_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    state_t        state_reg, state_next;
    logic [2:0]    in_cnt_reg, in_cnt_next;
    logic [2:0]    out_cnt_reg, out_cnt_next;
    logic [1:0]    stage_reg, stage_next;
    logic [1:0]    bfly_reg, bfly_next;

    logic [DW-1:0] buf_re_reg [N];
    logic [DW-1:0] buf_im_reg [N];

    logic          in_fire, out_fire;
    logic [2:0]    load_addr;
    logic [2:0]    p_addr, q_addr;
    logic [1:0]    tw_idx;
    logic          bf_we;
    logic [DW-1:0] x_re, x_im, y_re, y_im;

    assign in_ready  = rst_n && (state_reg == LOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_reg == UNLOAD);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state_reg != LOAD);
    assign load_addr = bitrev3(in_cnt_reg);
    assign bf_we     = (state_reg == COMPUTE);

    // Output view of the buffer; zero outside UNLOAD
    always_comb begin
        out_re   = '0;
        out_im   = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_re   = buf_re_reg[out_cnt_reg];
            out_im   = buf_im_reg[out_cnt_reg];
            out_idx  = out_cnt_reg;
            out_last = (out_cnt_reg == 3'd7);
        end
    end

    // Butterfly address generation: span = 2^s, p = grp*2*span + j,
    // q = p + span, twiddle t = j << (2 - s)
    always_comb begin
        p_addr = {bfly_reg, 1'b0};
        q_addr = {bfly_reg, 1'b1};
        tw_idx = 2'd0;
        case (stage_reg)
            2'd0: begin
                p_addr = {bfly_reg, 1'b0};
                q_addr = {bfly_reg, 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                p_addr = {bfly_reg[1], 1'b0, bfly_reg[0]};
                q_addr = {bfly_reg[1], 1'b1, bfly_reg[0]};
                tw_idx = {bfly_reg[0], 1'b0};
            end
            default: begin
                p_addr = {1'b0, bfly_reg};
                q_addr = {1'b1, bfly_reg};
                tw_idx = bfly_reg;
            end
        endcase
    end

    ifft8_butterfly u_bfly (
        .a_re (buf_re_reg[p_addr]),
        .a_im (buf_im_reg[p_addr]),
        .b_re (buf_re_reg[q_addr]),
        .b_im (buf_im_reg[q_addr]),
        .w_re (TW_RE[tw_idx]),
        .w_im (TW_IM[tw_idx]),
        .x_re (x_re),
        .x_im (x_im),
        .y_re (y_re),
        .y_im (y_im)
    );

    // State and counter registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= LOAD;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            stage_reg   <= '0;
            bfly_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            in_cnt_reg  <= in_cnt_next;
            out_cnt_reg <= out_cnt_next;
            stage_reg   <= stage_next;
            bfly_reg    <= bfly_next;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_next   = state_reg;
        in_cnt_next  = in_cnt_reg;
        out_cnt_next = out_cnt_reg;
        stage_next   = stage_reg;
        bfly_next    = bfly_reg;
        case (state_reg)
            LOAD: begin
                if (in_fire) begin
                    in_cnt_next = in_cnt_reg + 3'd1;
                    if (in_cnt_reg == 3'd7) state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                bfly_next = bfly_reg + 2'd1;
                if (bfly_reg == 2'd3) begin
                    stage_next = stage_reg + 2'd1;
                    if (stage_reg == 2'd2) begin
                        stage_next = 2'd0;
`ifdef IFFT_SCALE_EN
                        state_next = SCALE;
`else
                        state_next = UNLOAD;
`endif
                    end
                end
            end
            SCALE: state_next = UNLOAD;
            UNLOAD: begin
                if (out_fire) begin
                    out_cnt_next = out_cnt_reg + 3'd1;
                    if (out_cnt_reg == 3'd7) state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Per-entry buffer write: load bin, butterfly result, or 1/N scale
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (in_fire && (load_addr == 3'(gi))) begin
                    buf_re_reg[gi] <= in_re;
                    buf_im_reg[gi] <= in_im;
                end else if (bf_we && (p_addr == 3'(gi))) begin
                    buf_re_reg[gi] <= x_re;
                    buf_im_reg[gi] <= x_im;
                end else if (bf_we && (q_addr == 3'(gi))) begin
                    buf_re_reg[gi] <= y_re;
                    buf_im_reg[gi] <= y_im;
`ifdef IFFT_SCALE_EN
                end else if (state_reg == SCALE) begin
                    buf_re_reg[gi] <= DW'($signed(buf_re_reg[gi]) >>> SCALE_SHIFT);
                    buf_im_reg[gi] <= DW'($signed(buf_im_reg[gi]) >>> SCALE_SHIFT);
`endif
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ifft8_stream.sv
// tb_ifft8_stream: directed self-checking bench for ifft8_stream.
// Expected outputs are hand-derived unscaled values; with IFFT_SCALE_EN the
// bench applies the >>>3 normalisation to them itself.
module tb_ifft8_stream;

`ifdef IFFT_SCALE_EN
    localparam int SHIFT = 3;
    localparam int XTRA  = 1;
`else
    localparam int SHIFT = 0;
    localparam int XTRA  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    ifft8_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int last_acc_cyc = 0;
    int first_val_cyc = 0;
    int prev_first = 0;

    logic [31:0] fin_re [8];
    logic [31:0] fin_im [8];
    logic [31:0] exp_re [8];
    logic [31:0] exp_im [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] sc(input logic [31:0] v);
        return $signed(v) >>> SHIFT;
    endfunction

    // 0: impulse, 1: tone on bin 1, 2: mixed bins exercising truncation
    task automatic set_frame(input int kind);
        case (kind)
            0: begin
                fin_re = '{32'h10000, 0, 0, 0, 0, 0, 0, 0};
                fin_im = '{0, 0, 0, 0, 0, 0, 0, 0};
                exp_re = '{32'h10000, 32'h10000, 32'h10000, 32'h10000,
                           32'h10000, 32'h10000, 32'h10000, 32'h10000};
                exp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
            end
            1: begin
                fin_re = '{0, 32'h80000, 0, 0, 0, 0, 0, 0};
                fin_im = '{0, 0, 0, 0, 0, 0, 0, 0};
                exp_re = '{32'h80000, 32'h5A828, 32'h0, 32'hFFFA57D8,
                           32'hFFF80000, 32'hFFFA57D8, 32'h0, 32'h5A828};
                exp_im = '{32'h0, 32'h5A828, 32'h80000, 32'h5A828,
                           32'h0, 32'hFFFA57D8, 32'hFFF80000, 32'hFFFA57D8};
            end
            default: begin
                fin_re = '{0, 32'h1, 32'h10000, 0, 0, 0, 0, 0};
                fin_im = '{0, 32'h80000, 0, 0, 0, 0, 0, 0};
                exp_re = '{32'h10001, 32'hFFFA57D8, 32'hFFF70000, 32'hFFFA57D7,
                           32'h0000FFFF, 32'h5A828, 32'h70000, 32'h5A829};
                exp_im = '{32'h80000, 32'h6A828, 32'h1, 32'hFFF957D8,
                           32'hFFF80000, 32'hFFFB57D8, 32'hFFFFFFFF, 32'h4A828};
            end
        endcase
    endtask

    // Feed 8 bins; gap>0 inserts idle cycles before odd bins
    task automatic send_frame(input int gap, input bit hold);
        bit rdy;
        for (int k = 0; k < 8; k++) begin
            if (gap != 0 && (k % 2) == 1) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_re    = fin_re[k];
            in_im    = fin_im[k];
            rdy      = 1'b0;
            for (int w = 0; w < 100 && !rdy; w++) begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
            end
            chk($sformatf("in_accept[%0d]", k), 32'(rdy), 32'd1);
        end
        last_acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    // Drain 8 samples; bp applies the 1-0-0-1 out_ready pattern
    task automatic recv_frame(input bit bp, input bit no_rdy);
        int  n_xfer;
        bit  seen;
        n_xfer = 0;
        seen   = 1'b0;
        for (int c = 0; c < 300 && n_xfer < 8; c++) begin
            out_ready = !bp || (c % 4 == 0) || (c % 4 == 3);
            @(negedge clk);
            if (no_rdy) chk("in_ready_blocked", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    first_val_cyc = cyc;
                    chk("latency", first_val_cyc - last_acc_cyc, 12 + XTRA);
                end
                chk($sformatf("out_idx[%0d]", n_xfer), 32'(out_idx), n_xfer);
                chk($sformatf("out_re[%0d]", n_xfer), out_re, sc(exp_re[n_xfer]));
                chk($sformatf("out_im[%0d]", n_xfer), out_im, sc(exp_im[n_xfer]));
                chk($sformatf("out_last[%0d]", n_xfer), 32'(out_last), 32'(n_xfer == 7));
                if (out_ready) n_xfer++;
            end
            @(posedge clk);
            #1;
        end
        chk("xfer_count", n_xfer, 8);
        $display("frame received: %0d samples, first valid at cycle %0d", n_xfer, first_val_cyc);
    endtask

    // After a frame: back in LOAD, outputs idle and forced to zero
    task automatic post_check();
        @(negedge clk);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_re", out_re, 32'd0);
        chk("post_out_idx", 32'(out_idx), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_re     = '0;
        in_im     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_re", out_re, 32'd0);
        chk("rst_out_im", out_im, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Impulse, no stalls
        set_frame(0);
        send_frame(0, 1'b0);
        recv_frame(1'b0, 1'b0);
        post_check();

        // Tone with input gaps and output backpressure
        set_frame(1);
        send_frame(2, 1'b0);
        recv_frame(1'b1, 1'b0);
        post_check();

        // Mixed bins: truncation toward -inf and every twiddle path
        set_frame(2);
        send_frame(0, 1'b0);
        recv_frame(1'b1, 1'b0);
        post_check();

        // Reset during the fifth COMPUTE cycle
        set_frame(2);
        send_frame(0, 1'b0);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        set_frame(0);
        send_frame(0, 1'b0);
        recv_frame(1'b0, 1'b0);
        post_check();

        // Back-to-back: impulse then tone, in_valid held high throughout
        set_frame(0);
        send_frame(0, 1'b1);
        in_re = '0;
        in_im = '0;
        recv_frame(1'b0, 1'b1);
        prev_first = first_val_cyc;
        set_frame(1);
        send_frame(0, 1'b0);
        recv_frame(1'b0, 1'b0);
        chk("frame_period", first_val_cyc - prev_first, 28 + XTRA);
        post_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
